// File: rtl/pattern_delay_timer.sv
// pattern_delay_timer
//   Serial-triggered one-shot timer. Hunts the serial `data` stream for
//   PATTERN (MSB first, overlapping detection), then shifts in a DELAY_W-bit
//   delay value MSB first, asserts `counting` for (delay+1)*TICKS_PER_UNIT
//   cycles and finally holds `done` until `ack` (or `abort`).
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous reset, active-high
//   data       in   serial input, sampled every rising edge
//   ack        in   acknowledge, only looked at in DONE
//   abort      in   synchronous cancel (SHIFT, COUNT, DONE)
//   counting   out  high for every cycle of the timed interval
//   done       out  high from end of interval until ack/abort
//   remaining  out  whole delay units left in the current interval
//   state      out  debug view of the FSM state
//
// state  | meaning
// -------+------------------------------------------------------------
// SEARCH | hunting for PATTERN in the serial stream
// SHIFT  | collecting DELAY_W delay bits, MSB first
// COUNT  | timed interval running, counting=1
// DONE   | interval finished, done=1 until ack/abort
module pattern_delay_timer #(
  parameter int                   PATTERN_W      = 4,
  parameter logic [PATTERN_W-1:0] PATTERN        = 4'b1101,
  parameter int                   DELAY_W        = 4,
  parameter int                   TICKS_PER_UNIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  input  logic               abort,
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] remaining,
  output logic [1:0]         state
);

  localparam int UNIT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int IDX_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
  localparam logic [UNIT_W-1:0] UNIT_RELOAD = UNIT_W'(TICKS_PER_UNIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(DELAY_W - 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SHIFT  = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] shreg_q, shreg_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [UNIT_W-1:0]    unit_q, unit_d;
  logic [DELAY_W-1:0]   rem_q, rem_d;
  logic                 counting_q, counting_d;
  logic                 done_q, done_d;

  logic [PATTERN_W-1:0] pat_next;
  logic [DELAY_W-1:0]   delay_next;
  logic                 match;

  // Shift-left forms keep DELAY_W=1 legal (no [W-2:0] slice needed).
  assign pat_next   = (shreg_q << 1) | PATTERN_W'(data);
  assign delay_next = (delay_q << 1) | DELAY_W'(data);
  assign match      = (pat_next == PATTERN);

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_SEARCH;
      shreg_q    <= '0;
      delay_q    <= '0;
      idx_q      <= '0;
      unit_q     <= '0;
      rem_q      <= '0;
      counting_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      delay_q    <= delay_d;
      idx_q      <= idx_d;
      unit_q     <= unit_d;
      rem_q      <= rem_d;
      counting_q <= counting_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SEARCH: if (match) state_d = S_SHIFT;
      S_SHIFT: begin
        if (abort)                  state_d = S_SEARCH;
        else if (idx_q == IDX_LAST) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (abort)                                  state_d = S_SEARCH;
        else if (unit_q == '0 && rem_q == '0)       state_d = S_DONE;
      end
      S_DONE: if (abort || ack) state_d = S_SEARCH;
    endcase
  end

  // Datapath: pattern register, delay capture, unit/remaining counters.
  always_comb begin
    shreg_d = shreg_q;
    delay_d = delay_q;
    idx_d   = idx_q;
    unit_d  = unit_q;
    rem_d   = rem_q;

    // Re-entering SEARCH starts from a clean history so nothing seen in
    // SHIFT/COUNT/DONE (or on the ack cycle) can complete a match.
    if (state_q == S_SEARCH)      shreg_d = pat_next;
    else if (state_d == S_SEARCH) shreg_d = '0;

    unique case (state_q)
      S_SEARCH: begin
        delay_d = '0;
        idx_d   = '0;
        unit_d  = '0;
        rem_d   = '0;
      end
      S_SHIFT: begin
        delay_d = delay_next;
        idx_d   = idx_q + IDX_W'(1);
        if (state_d == S_COUNT) begin
          unit_d = UNIT_RELOAD;
          rem_d  = delay_next;
        end
      end
      S_COUNT: begin
        if (state_d != S_COUNT) begin
          unit_d = '0;
          rem_d  = '0;
        end else if (unit_q == '0) begin
          unit_d = UNIT_RELOAD;
          rem_d  = rem_q - DELAY_W'(1);
        end else begin
          unit_d = unit_q - UNIT_W'(1);
        end
      end
      S_DONE: begin
        unit_d = '0;
        rem_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they line up with state_q.
  always_comb begin
    counting_d = (state_d == S_COUNT);
    done_d     = (state_d == S_DONE);
  end

  assign counting  = counting_q;
  assign done      = done_q;
  assign remaining = rem_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pattern_delay_timer.sv
// tb_pattern_delay_timer
//   Directed bench for pattern_delay_timer. Two instances: the default
//   4-bit 1101 / 4-bit delay configuration and a 3-bit 101 / 2-bit delay
//   configuration, both with TICKS_PER_UNIT=10. A cycle-level model
//   (cycles-left arithmetic) is compared against every output on every
//   falling edge; directed literal checks pin the model.
module tb_pattern_delay_timer;

  localparam int TPU = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data = 1'b0, ack = 1'b0, abort = 1'b0;
  logic       data2 = 1'b0, ack2 = 1'b0, abort2 = 1'b0;
  logic       counting, done, counting2, done2;
  logic [3:0] remaining;
  logic [1:0] remaining2;
  logic [1:0] state, state2;

  int checks = 0;
  int errors = 0;
  int rems[0:299];
  bit live = 0;

  always #5 clk = ~clk;

  pattern_delay_timer #(
    .PATTERN_W(4), .PATTERN(4'b1101), .DELAY_W(4), .TICKS_PER_UNIT(TPU)
  ) dut1 (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .abort(abort),
    .counting(counting), .done(done), .remaining(remaining), .state(state)
  );

  pattern_delay_timer #(
    .PATTERN_W(3), .PATTERN(3'b101), .DELAY_W(2), .TICKS_PER_UNIT(TPU)
  ) dut2 (
    .clk(clk), .reset(reset), .data(data2), .ack(ack2), .abort(abort2),
    .counting(counting2), .done(done2), .remaining(remaining2), .state(state2)
  );

  // mode: 0 hunt, 1 collecting delay bits, 2 timing, 3 holding done
  typedef struct {
    int mode;
    int hist;
    int nbits;
    int dval;
    int left;
  } mdl_t;

  mdl_t m1 = '{0, 0, 0, 0, 0};
  mdl_t m2 = '{0, 0, 0, 0, 0};

  function automatic mdl_t mstep(input mdl_t m, input int pw, input int pat,
                                 input int dw, input int tpu, input logic r,
                                 input logic d, input logic a, input logic ab);
    mdl_t n = m;
    if (r) begin
      n = '{0, 0, 0, 0, 0};
    end else if (ab && m.mode != 0) begin
      n.mode = 0;
      n.hist = 0;
    end else begin
      case (m.mode)
        0: begin
          n.hist = ((m.hist << 1) | int'(d)) & ((1 << pw) - 1);
          if (n.hist == pat) begin
            n.mode = 1; n.nbits = 0; n.dval = 0;
          end
        end
        1: begin
          n.dval  = m.dval * 2 + int'(d);
          n.nbits = m.nbits + 1;
          if (n.nbits == dw) begin
            n.mode = 2;
            n.left = (n.dval + 1) * tpu;
          end
        end
        2: begin
          n.left = m.left - 1;
          if (n.left == 0) n.mode = 3;
        end
        3: if (a) begin n.mode = 0; n.hist = 0; end
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m1 = mstep(m1, 4, 13, 4, TPU, reset, data, ack, abort);
    m2 = mstep(m2, 3, 5, 2, TPU, reset, data2, ack2, abort2);
    if (reset) live = 1;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("m1_counting",  32'(counting),  32'(m1.mode == 2));
      chk("m1_done",      32'(done),      32'(m1.mode == 3));
      chk("m1_remaining", 32'(remaining), (m1.mode == 2) ? 32'((m1.left - 1) / TPU) : 32'd0);
      chk("m1_state",     32'(state),     32'(m1.mode));
      chk("m2_counting",  32'(counting2), 32'(m2.mode == 2));
      chk("m2_done",      32'(done2),     32'(m2.mode == 3));
      chk("m2_remaining", 32'(remaining2), (m2.mode == 2) ? 32'((m2.left - 1) / TPU) : 32'd0);
      chk("m2_state",     32'(state2),    32'(m2.mode));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] bits, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      data = bits[i];
      step();
    end
    data = 1'b0;
  endtask

  task automatic send2(input logic [31:0] bits, input int nb);
    for (int i = nb - 1; i >= 0; i--) begin
      data2 = bits[i];
      step();
    end
    data2 = 1'b0;
  endtask

  // Counts consecutive counting cycles (bounded), logging remaining per cycle.
  task automatic measure(input int sel, output int n);
    n = 0;
    while (((sel == 1) ? counting : counting2) && n < 300) begin
      rems[n] = (sel == 1) ? int'(remaining) : int'(remaining2);
      step();
      n++;
    end
  endtask

  task automatic idle_no_count(input string nm, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (counting) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    int n;
    int sd;
    logic [6:0] done_bits;

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_counting", 32'(counting), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);

    // 1: 1101 then delay 0010 -> 30 counting cycles
    send1(32'b1101_0010, 8);
    chk("t1_rise", 32'(counting), 32'd1);
    measure(1, n);
    chk("t1_len", 32'(n), 32'd30);
    chk("t1_rem0", 32'(rems[0]), 32'd2);
    chk("t1_rem9", 32'(rems[9]), 32'd2);
    chk("t1_rem10", 32'(rems[10]), 32'd1);
    chk("t1_rem19", 32'(rems[19]), 32'd1);
    chk("t1_rem20", 32'(rems[20]), 32'd0);
    chk("t1_rem29", 32'(rems[29]), 32'd0);
    chk("t1_done", 32'(done), 32'd1);

    // 2: DONE holds through pattern-like data; ack clears
    done_bits = 7'b1101011;
    for (int i = 6; i >= 0; i--) begin
      data = done_bits[i];
      step();
      chk("t2_done_hold", 32'(done), 32'd1);
    end
    ack = 1'b1; data = 1'b0;
    step();
    ack = 1'b0; data = 1'b1;
    chk("t2_done_clr", 32'(done), 32'd0);
    step();
    data = 1'b0;
    idle_no_count("t2_no_match", 12);

    // 3: overlapping match, delay 0 -> 10 cycles
    send1(32'b1_1101_0000, 9);
    chk("t3_rise", 32'(counting), 32'd1);
    measure(1, n);
    chk("t3_len", 32'(n), 32'd10);
    chk("t3_rem0", 32'(rems[0]), 32'd0);
    chk("t3_done", 32'(done), 32'd1);
    ack = 1'b1; abort = 1'b1;
    step();
    ack = 1'b0; abort = 1'b0;
    chk("t3_ackabort", 32'(done), 32'd0);

    // 4: maximum delay 1111 -> 160 cycles
    send1(32'b1101_1111, 8);
    measure(1, n);
    chk("t4_len", 32'(n), 32'd160);
    chk("t4_rem0", 32'(rems[0]), 32'd15);
    chk("t4_rem10", 32'(rems[10]), 32'd14);
    chk("t4_rem159", 32'(rems[159]), 32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // 5a: abort on cycle 12 of COUNT
    send1(32'b1101_0011, 8);
    for (int i = 0; i < 11; i++) step();
    chk("t5_rem_c12", 32'(remaining), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_cnt", 32'(counting), 32'd0);
    chk("t5_abort_rem", 32'(remaining), 32'd0);
    chk("t5_abort_state", 32'(state), 32'd0);
    sd = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done) sd++;
    end
    chk("t5_no_done", 32'(sd), 32'd0);

    // 5b: abort during SHIFT
    send1(32'b1101_10, 6);
    chk("t5b_shift", 32'(state), 32'd1);
    abort = 1'b1; data = 1'b1;
    step();
    abort = 1'b0; data = 1'b0;
    chk("t5b_search", 32'(state), 32'd0);
    send1(32'b11, 2);
    idle_no_count("t5b_no_count", 12);

    // 6: reset after 2nd delay bit
    send1(32'b1101_00, 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_cnt", 32'(counting), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_rem", 32'(remaining), 32'd0);
    chk("t6_state", 32'(state), 32'd0);
    send1(32'b11, 2);
    idle_no_count("t6_partial", 12);
    send1(32'b1101_0001, 8);
    measure(1, n);
    chk("t6_len", 32'(n), 32'd20);
    chk("t6_rem0", 32'(rems[0]), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;

    // 4b: 3-bit pattern 101, 2-bit delay: 1,0,1 | 1,0 -> delay 2, 30 cycles
    send2(32'b101_10, 5);
    chk("t4b_rise", 32'(counting2), 32'd1);
    measure(2, n);
    chk("t4b_len", 32'(n), 32'd30);
    chk("t4b_rem0", 32'(rems[0]), 32'd2);
    chk("t4b_rem10", 32'(rems[10]), 32'd1);
    chk("t4b_done", 32'(done2), 32'd1);
    ack2 = 1'b1;
    step();
    ack2 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_delay_timer.md
Name: pattern_delay_timer

Overview:
- Serial-triggered one-shot timer and parametrised successor of the fixed 1101/4-bit/1000-cycle timer.
- Hunts a serial `data` stream for a configurable start pattern, then shifts in a DELAY_W-bit delay MSB-first.
- Asserts `counting` for exactly (delay+1)*TICKS_PER_UNIT cycles, then holds `done` until acknowledged.
- New versus the previous generation: parametrised pattern/widths/period, a `remaining` time output, and an `abort` input. Sits in the lab3 control path next to the serial receiver.

Parameters:
- PATTERN_W, 4: start-pattern length in bits (>=2).
- PATTERN, 4'b1101: start pattern; MSB is received first.
- DELAY_W, 4: delay field width in bits (>=1).
- TICKS_PER_UNIT, 1000: clock cycles per delay unit (>=1); benches use 10.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- data  in  1  serial input, sampled every rising edge.
- ack  in  1  acknowledge; sampled only in DONE.
- abort  in  1  synchronous cancel of an in-progress operation.
- counting  out  1  high for every cycle of the timed interval.
- done  out  1  high from end of interval until ack/abort.
- remaining  out  DELAY_W  whole units left in the current interval.

Behaviour:
- One clock, `clk`. `reset` is synchronous and active-high.
- Reset: state=SEARCH, pattern shift register=0, delay=0, counters=0. counting=0, done=0, remaining=0, all registered.
- Priority each edge: reset > abort > normal operation.
- SEARCH:
  - PATTERN_W-bit shift register; new bit enters at LSB.
  - Overlapping detection: 1,1,1,0,1 matches 1101 on the 5th bit.
  - On the edge where shreg[PATTERN_W-2:0] concatenated with data equals PATTERN, go to SHIFT with bit index=0.
  - abort has no effect here.
- SHIFT:
  - DELAY_W consecutive edges sample data into delay, MSB first.
  - On the edge sampling the last bit, go to COUNT and load: unit counter=TICKS_PER_UNIT-1, remaining=full delay value (including that bit).
  - counting=1 from the cycle immediately after the last delay bit.
- COUNT:
  - counting=1 throughout.
  - Unit counter decrements each cycle.
  - When the unit counter is 0 and remaining>0: remaining decrements, unit counter reloads TICKS_PER_UNIT-1.
  - When the unit counter is 0 and remaining==0: go to DONE.
  - counting is high for exactly (delay+1)*TICKS_PER_UNIT cycles. delay=0 gives TICKS_PER_UNIT cycles; delay=2^DELAY_W-1 gives 2^DELAY_W*TICKS_PER_UNIT cycles, with no wrap.
- DONE:
  - done=1, counting=0, remaining=0. data is ignored.
  - ack=1 at an edge goes to SEARCH; done=0 the next cycle.
  - On entering SEARCH the pattern register clears to 0, so bits received during DONE or the ack cycle never contribute to a match.
- abort=1 in SHIFT, COUNT or DONE: next cycle state=SEARCH, pattern register cleared, counting=0, done=0, remaining=0. No done pulse is produced.
- ack outside DONE is ignored.
- abort and ack together in DONE have the same result.
- Reset mid-operation behaves the same as power-up reset; the pattern must be resent in full.
- Counter widths:
  - unit counter is clog2(TICKS_PER_UNIT) bits, minimum 1.
  - remaining is DELAY_W bits.
- Outputs are registered with no combinational path from inputs. The reference state encoding is SEARCH=0, SHIFT=1, COUNT=2, DONE=3, visible as `state` for debug probes.

Test Plan:
1. Defaults with TICKS_PER_UNIT=10. Reset 2 cycles, then data 1,1,0,1, then 0,0,1,0.
   - counting rises the cycle after the 8th bit and stays high exactly 30 cycles.
   - remaining reads 2 for 10 cycles, then 1 for 10, then 0 for 10.
   - done rises the cycle counting falls.
2. Hold ack=0 for 7 cycles in DONE while driving 1,1,0,1 on data, then pulse ack.
   - done stays 1 the whole time.
   - done=0 the next cycle.
   - No spurious match; a fresh 1101 is required to start again.
3. Overlap: data 1,1,1,0,1,0,0,0,0 → match on the 5th bit; delay=0; counting high exactly 10 cycles.
4. Maximum delay 1,1,1,1 → remaining starts at 15 and counting lasts 160 cycles.
   - Separate config PATTERN_W=3, PATTERN=3'b101, DELAY_W=2 with data 1,0,1,1,0 → delay=2, 30 cycles.
5. Abort:
   - abort at cycle 12 of COUNT → counting=0 and remaining=0 next cycle; done never asserts.
   - abort during SHIFT → back to SEARCH.
6. Reset asserted after the 2nd delay bit → all outputs 0 next cycle.
   - Resending the remaining 2 delay bits alone does not start counting.
   - The full pattern plus delay then works.
